// File: rtl/mem_access_unit.sv
// Memory-access stage: byte/half/word loads and stores on a handshaked word memory,
// sub-word stores via read-modify-write. Define MEM_TIMEOUT_EN to abort stalled requests.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MODIFY,
        S_WR,
        S_DONE
    } state_t;

    state_t      state_q;
    logic        busy_q, done_q, err_q, req_q, we_q;
    logic [31:0] rdata_q, mwdata_q;
    logic [29:0] maddr_q;
    logic [1:0]  size_q, lane_q;
    logic        sign_q, load_q;
    logic [15:0] store_q;

    logic        accept_d, illegal_d, expire_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [31:0] load_d, merge_d;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] cnt_q;

    // Counts consecutive unanswered request cycles; clears on every RD/WR entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == S_RD || state_q == S_WR) && !mem_ready) begin
            cnt_q <= cnt_q + CW'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    assign expire_d = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
    assign expire_d = 1'b0;
`endif

    always_comb begin
        accept_d  = start && (mem_read || mem_write) &&
                    (state_q == S_IDLE || state_q == S_DONE);
        illegal_d = (mem_read && mem_write) ||
                    (size == 2'b11) ||
                    (size == 2'b01 && addr[0]) ||
                    (size == 2'b10 && addr[1:0] != 2'b00);

        byte_d = mem_rdata[{lane_q, 3'b000} +: 8];
        half_d = mem_rdata[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   load_d = sign_q ? {{24{byte_d[7]}}, byte_d} : {24'h0, byte_d};
            2'b01:   load_d = sign_q ? {{16{half_d[15]}}, half_d} : {16'h0, half_d};
            default: load_d = mem_rdata;
        endcase

        // mwdata_q holds the word captured in RD; overlay the store lane onto it.
        merge_d = mwdata_q;
        if (size_q == 2'b00) begin
            merge_d[{lane_q, 3'b000} +: 8] = store_q[7:0];
        end else begin
            merge_d[{lane_q[1], 4'b0000} +: 16] = store_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            size_q   <= '0;
            lane_q   <= '0;
            sign_q   <= 1'b0;
            load_q   <= 1'b0;
            store_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    if (accept_d) begin
                        size_q  <= size;
                        lane_q  <= addr[1:0];
                        sign_q  <= sign_ext;
                        load_q  <= mem_read;
                        store_q <= wdata[15:0];
                        maddr_q <= addr[31:2];
                        if (illegal_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else if (mem_read) begin
                            state_q <= S_RD;
                            busy_q  <= 1'b1;
                            req_q   <= 1'b1;
                        end else if (size == 2'b10) begin
                            state_q  <= S_WR;
                            busy_q   <= 1'b1;
                            req_q    <= 1'b1;
                            we_q     <= 1'b1;
                            mwdata_q <= wdata;
                        end else begin
                            state_q <= S_RD;
                            busy_q  <= 1'b1;
                            req_q   <= 1'b1;
                        end
                    end
                end

                S_RD: begin
                    if (mem_ready) begin
                        req_q <= 1'b0;
                        if (load_q) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            rdata_q <= load_d;
                        end else begin
                            state_q  <= S_MODIFY;
                            mwdata_q <= mem_rdata;
                        end
                    end else if (expire_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                        rdata_q <= '0;
                    end
                end

                S_MODIFY: begin
                    state_q  <= S_WR;
                    mwdata_q <= merge_d;
                    req_q    <= 1'b1;
                    we_q     <= 1'b1;
                end

                S_WR: begin
                    if (mem_ready || expire_d) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= !mem_ready;
                        req_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (!mem_ready) begin
                            rdata_q <= '0;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a stallable word-memory responder.
module tb_mem_access_unit;

    logic        clk, rst, start, mem_read, mem_write, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic        busy, done, err, mem_req, mem_we, mem_ready;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [29:0] mem_addr;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_read(mem_read), .mem_write(mem_write),
        .size(size), .sign_ext(sign_ext), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .rdata(rdata), .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [16];
    int          stall_rd = 0;
    int          stall_wr = 0;
    int          wr_count = 0;
    logic [29:0] last_wr_addr = '0;
    logic [31:0] last_wr_data = '0;

    int          lat, busy_cnt;
    logic        req_seen, req_at_done, got_err;
    logic [31:0] got_rdata;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Responder: holds mem_ready low for the configured number of request cycles.
    initial begin
        int wcnt;
        int lim;
        wcnt = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                lim = mem_we ? stall_wr : stall_rd;
                if (wcnt < lim) begin
                    mem_ready = 1'b0;
                    wcnt++;
                end else begin
                    mem_ready = 1'b1;
                    wcnt = 0;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt = 0;
            end
            mem_rdata = mem[mem_addr[3:0]];
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && mem_req && mem_we && mem_ready) begin
                mem[mem_addr[3:0]] = mem_wdata;
                last_wr_addr = mem_addr;
                last_wr_data = mem_wdata;
                wr_count++;
            end
        end
    end

    // Called at a negedge; drives start for one cycle and runs until done (bounded).
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sx, input logic [31:0] a, input logic [31:0] wd);
        start = 1'b1; mem_read = rd; mem_write = wr; size = sz; sign_ext = sx;
        addr = a; wdata = wd;
        @(negedge clk);
        start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        lat = 1; busy_cnt = 0; req_seen = 1'b0;
        while (!done && lat < 60) begin
            if (busy) busy_cnt++;
            if (mem_req) req_seen = 1'b1;
            @(negedge clk);
            lat++;
        end
        req_at_done = mem_req;
        got_rdata = rdata;
        got_err = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin
            $display("FAIL reset_flags got=%b exp=00000", {busy, done, err, mem_req, mem_we});
            failures++;
        end
        checks++;
        if (rdata !== 32'h0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0) begin
            $display("FAIL reset_data got rdata=%h addr=%h wdata=%h exp=0", rdata, mem_addr, mem_wdata);
            failures++;
        end
        rst = 1'b0;
    endtask

    task automatic test_word_load();
        @(negedge clk);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (lat !== 2) begin $display("FAIL wload_lat got=%0d exp=2", lat); failures++; end
        checks++;
        if (got_rdata !== 32'hDEADBEEF) begin $display("FAIL wload_data got=%h exp=deadbeef", got_rdata); failures++; end
        checks++;
        if (got_err !== 1'b0 || busy_cnt !== 1) begin
            $display("FAIL wload_err_busy got err=%b busy=%0d exp err=0 busy=1", got_err, busy_cnt); failures++;
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || rdata !== 32'hDEADBEEF) begin
            $display("FAIL wload_hold got done=%b rdata=%h exp done=0 rdata=deadbeef", done, rdata); failures++;
        end
    endtask

    task automatic test_subword_load();
        logic [31:0] a_t [5] = '{32'h13, 32'h13, 32'h16, 32'h16, 32'h14};
        logic [1:0]  s_t [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
        logic        x_t [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] e_t [5] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFF8001, 32'h00008001, 32'h00007FFE};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            issue(1'b1, 1'b0, s_t[i], x_t[i], a_t[i], 32'h0);
            checks++;
            if (got_rdata !== e_t[i] || lat !== 2 || got_err !== 1'b0) begin
                $display("FAIL subload_%0d got=%h lat=%0d err=%b exp=%h lat=2 err=0",
                         i, got_rdata, lat, got_err, e_t[i]);
                failures++;
            end
        end
    endtask

    task automatic test_half_store();
        int wc0;
        wc0 = wr_count;
        stall_rd = 3;
        @(negedge clk);
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h00001234);
        stall_rd = 0;
        checks++;
        if (lat !== 7) begin $display("FAIL hstore_lat got=%0d exp=7", lat); failures++; end
        checks++;
        if (busy_cnt !== 6) begin $display("FAIL hstore_busy got=%0d exp=6", busy_cnt); failures++; end
        checks++;
        if (last_wr_data !== 32'h1234BEEF || last_wr_addr !== 30'h4 || wr_count !== wc0 + 1) begin
            $display("FAIL hstore_write got=%h@%h n=%0d exp=1234beef@4 n=%0d",
                     last_wr_data, last_wr_addr, wr_count, wc0 + 1);
            failures++;
        end
    endtask

    task automatic test_byte_store();
        @(negedge clk);
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAB);
        checks++;
        if (lat !== 4 || got_err !== 1'b0) begin
            $display("FAIL bstore_lat got=%0d err=%b exp=4 err=0", lat, got_err); failures++;
        end
        checks++;
        if (last_wr_data !== 32'h1122AB44 || last_wr_addr !== 30'h8) begin
            $display("FAIL bstore_write got=%h@%h exp=1122ab44@8", last_wr_data, last_wr_addr); failures++;
        end
    endtask

    task automatic test_word_store();
        stall_wr = 2;
        @(negedge clk);
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h18, 32'hCAFEF00D);
        stall_wr = 0;
        checks++;
        if (lat !== 4 || busy_cnt !== 3) begin
            $display("FAIL wstore_lat got=%0d busy=%0d exp=4 busy=3", lat, busy_cnt); failures++;
        end
        checks++;
        if (last_wr_data !== 32'hCAFEF00D || last_wr_addr !== 30'h6) begin
            $display("FAIL wstore_write got=%h@%h exp=cafef00d@6", last_wr_data, last_wr_addr); failures++;
        end
    endtask

    task automatic test_back_to_back();
        int wc0;
        wc0 = wr_count;
        @(negedge clk);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        checks++;
        if (lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0 || req_seen !== 1'b0) begin
            $display("FAIL illegal_wload got lat=%0d err=%b rdata=%h req=%b exp 1 1 0 0",
                     lat, got_err, got_rdata, req_seen);
            failures++;
        end
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (lat !== 2 || got_err !== 1'b0 || got_rdata !== 32'h1234BEEF) begin
            $display("FAIL b2b_load got lat=%0d err=%b rdata=%h exp 2 0 1234beef", lat, got_err, got_rdata);
            failures++;
        end
        issue(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        checks++;
        if (lat !== 1 || got_err !== 1'b1 || got_rdata !== 32'h0) begin
            $display("FAIL illegal_size got lat=%0d err=%b rdata=%h exp 1 1 0", lat, got_err, got_rdata);
            failures++;
        end
        issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h0);
        checks++;
        if (lat !== 1 || got_err !== 1'b1 || req_seen !== 1'b0) begin
            $display("FAIL illegal_rdwr got lat=%0d err=%b req=%b exp 1 1 0", lat, got_err, req_seen);
            failures++;
        end
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h15, 32'h5555);
        checks++;
        if (lat !== 1 || got_err !== 1'b1 || wr_count !== wc0) begin
            $display("FAIL illegal_hstore got lat=%0d err=%b writes=%0d exp 1 1 %0d", lat, got_err, wr_count, wc0);
            failures++;
        end
    endtask

    task automatic test_ignored();
        @(negedge clk);
        start = 1'b1; mem_read = 1'b0; mem_write = 1'b0; size = 2'b10; addr = 32'h10;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_req !== 1'b0) begin
            $display("FAIL ignored_start got busy=%b done=%b req=%b exp 0 0 0", busy, done, mem_req);
            failures++;
        end
    endtask

    task automatic test_reset_mid_wr();
        int  wc0;
        logic saw_done;
        wc0 = wr_count;
        stall_wr = 100;
        @(negedge clk);
        start = 1'b1; mem_read = 1'b0; mem_write = 1'b1; size = 2'b10; addr = 32'h1C; wdata = 32'h0BADF00D;
        @(negedge clk);
        start = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            $display("FAIL rstwr_inwr got req=%b we=%b exp 1 1", mem_req, mem_we); failures++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            $display("FAIL rstwr_after got req=%b busy=%b done=%b we=%b exp 0 0 0 0", mem_req, busy, done, mem_we);
            failures++;
        end
        saw_done = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        stall_wr = 0;
        checks++;
        if (saw_done !== 1'b0 || wr_count !== wc0) begin
            $display("FAIL rstwr_nodone got done_seen=%b writes=%0d exp 0 %0d", saw_done, wr_count, wc0);
            failures++;
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        stall_rd = 1000;
        @(negedge clk);
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        stall_rd = 0;
        checks++;
        if (lat !== 5 || busy_cnt !== 4) begin
            $display("FAIL timeout_lat got=%0d busy=%0d exp=5 busy=4", lat, busy_cnt); failures++;
        end
        checks++;
        if (got_err !== 1'b1 || got_rdata !== 32'h0 || req_at_done !== 1'b0) begin
            $display("FAIL timeout_flags got err=%b rdata=%h req=%b exp 1 0 0", got_err, got_rdata, req_at_done);
            failures++;
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[4] = 32'hDEADBEEF;
        mem[5] = 32'h80017FFE;
        mem[8] = 32'h11223344;
        test_reset();
        test_word_load();
        test_subword_load();
        test_half_store();
        test_byte_store();
        test_word_store();
        test_back_to_back();
        test_ignored();
        test_reset_mid_wr();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
